branch_predictor: RTL and testbench

//  Dynamic branch direction predictor feeding the Fetch next-PC/flush logic.
//  - Table of 2-bit saturating counters, read with IF_pc.
//  - The prediction travels IF->ID->EX and is presented in ID as ID_branch_prediction.
//  - The EX-stage outcome is compared with the prediction to produce prediction_status.
//  - The counter is trained at EX resolution.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_counter_table.sv | 49 ++++
 rtl/branch_predictor.sv | 101 ++++++++++
 tb/tb_branch_predictor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants, FSM encoding and saturating-counter helper for branch_predictor.
package bp_pkg;

  localparam logic [1:0] ST_MISS_NT = 2'd0;
  localparam logic [1:0] ST_MISS_T  = 2'd1;
  localparam logic [1:0] ST_HIT     = 2'd2;
  localparam logic [1:0] ST_NONE    = 2'd3;

  localparam logic [1:0] CTR_MIN = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_MAX = 2'b11;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bp_state_e;

  // Move one step toward the resolved direction, clamping at both ends.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_MAX)) nxt = ctr + 2'd1;
    else if (!taken && (ctr != CTR_MIN)) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// 2^IDX_W x 2-bit counter table: async read, sync training write and the
// power-up sweep that fills every entry with weakly-not-taken.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             train_en,
  input  logic             train_taken,
  input  logic [IDX_W-1:0] train_idx,
  output logic             run,
  output logic             init_done
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       mem [ENTRIES];
  bp_state_e        state;
  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= (state == S_RUN);
      if (state == S_INIT) begin
        ptr <= ptr + 1'b1;
        if (ptr == '1) state <= S_RUN;
      end
    end
  end

  // NOTE: the storage array has no reset; the sweep gives every entry a known
  // value before any read is allowed to see it.
  always_ff @(posedge clk) begin
    if (state == S_INIT) mem[ptr] <= CTR_WNT;
    else if (train_en) mem[train_idx] <= ctr_step(mem[train_idx], train_taken);
  end

  assign run    = (state == S_RUN);
  assign rd_ctr = run ? mem[rd_idx] : CTR_MIN;

endmodule

// File: rtl/branch_predictor.sv
// Branch direction predictor: IF lookup, IF->ID->EX prediction pipe, EX verdict
// and training. Define BP_GSHARE_EN to hash the index with global history.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_pc,
  input  logic        ID_Stall,
  input  logic        ID_Flush,
  input  logic        EX_Flush,
  input  logic        EX_Branch,
  input  logic        EX_branch_taken,
  output logic [1:0]  ID_branch_prediction,
  output logic [1:0]  prediction_status,
  output logic        init_done
);

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ID_idx;
  logic [IDX_W-1:0] EX_idx;
  logic [1:0]       if_ctr;
  logic [1:0]       EX_pred;
  logic             run;
  logic             train_en;
  logic             unused_bits;

  assign train_en    = run & EX_Branch;
  assign unused_bits = ^{IF_pc[31:IDX_W+2], IF_pc[1:0], EX_pred[0]};

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr;

  assign if_idx = IF_pc[IDX_W+1:2] ^ IDX_W'(ghr);

  // History is speculative-free: it only moves on resolved branches, and a
  // flush never rewinds it.
  always_ff @(posedge clk) begin
    if (rst) ghr <= '0;
    else if (train_en) ghr <= HIST_W'({ghr, EX_branch_taken});
  end
`else
  localparam int unused_hist_w = HIST_W;

  assign if_idx = IF_pc[IDX_W+1:2];
`endif

  bp_counter_table #(
    .IDX_W(IDX_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (if_idx),
    .rd_ctr     (if_ctr),
    .train_en   (train_en),
    .train_taken(EX_branch_taken),
    .train_idx  (EX_idx),
    .run        (run),
    .init_done  (init_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ID_branch_prediction <= CTR_MIN;
      ID_idx               <= '0;
      EX_pred              <= CTR_MIN;
      EX_idx               <= '0;
    end else begin
      if (ID_Flush) begin
        ID_branch_prediction <= CTR_MIN;
        ID_idx               <= '0;
      end else if (!ID_Stall) begin
        ID_branch_prediction <= if_ctr;
        ID_idx               <= if_idx;
      end
      // A stalled ID must not also advance into EX, so EX takes a bubble.
      if (EX_Flush || ID_Stall) begin
        EX_pred <= CTR_MIN;
        EX_idx  <= '0;
      end else begin
        EX_pred <= ID_branch_prediction;
        EX_idx  <= ID_idx;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    prediction_status = ST_NONE;
    if (EX_Branch) begin
      if (EX_branch_taken == EX_pred[1]) prediction_status = ST_HIT;
      else if (EX_branch_taken)          prediction_status = ST_MISS_NT;
      else                               prediction_status = ST_MISS_T;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor (bimodal build) against
// a table-of-integers reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_pc;
  logic        ID_Stall, ID_Flush, EX_Flush, EX_Branch, EX_branch_taken;
  logic [1:0]  ID_branch_prediction;
  logic [1:0]  prediction_status;
  logic        init_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: counters as plain integers, plus the prediction/index
  // carried by the instruction currently in ID and in EX.
  int mtab[64];
  int m_edges;
  int m_id_pred, m_id_idx, m_ex_pred, m_ex_idx;

  logic [1:0] last_status;
  logic [1:0] last_id;

  branch_predictor dut (
    .clk                 (clk),
    .rst                 (rst),
    .IF_pc               (IF_pc),
    .ID_Stall            (ID_Stall),
    .ID_Flush            (ID_Flush),
    .EX_Flush            (EX_Flush),
    .EX_Branch           (EX_Branch),
    .EX_branch_taken     (EX_branch_taken),
    .ID_branch_prediction(ID_branch_prediction),
    .prediction_status   (prediction_status),
    .init_done           (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    IF_pc = 32'h0; ID_Stall = 1'b0; ID_Flush = 1'b0; EX_Flush = 1'b0;
    EX_Branch = 1'b0; EX_branch_taken = 1'b0;
    @(posedge clk);
    #1;
    m_edges = 0;
    m_id_pred = 0; m_id_idx = 0; m_ex_pred = 0; m_ex_idx = 0;
    check("rst_id_pred", ID_branch_prediction, 2'b00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_status", prediction_status, 2'd3);
    rst = 1'b0;
  endtask

  // One clock: drive, check the EX verdict mid-cycle, then advance the model
  // across the edge and check the registered outputs.
  task automatic cycle(input logic [31:0] pc, input bit idf, input bit ids,
                       input bit exf, input bit exb, input bit ext);
    int rd, nidx, t, exp_st;
    bit running;
    IF_pc = pc; ID_Flush = idf; ID_Stall = ids; EX_Flush = exf;
    EX_Branch = exb; EX_branch_taken = ext;
    @(negedge clk);
    if (!exb)                      exp_st = 3;
    else if (ext && m_ex_pred < 2)  exp_st = 0;
    else if (!ext && m_ex_pred >= 2) exp_st = 1;
    else                           exp_st = 2;
    last_status = prediction_status;
    check("status", prediction_status, exp_st[1:0]);
    @(posedge clk);
    running = (m_edges >= 64);
    nidx = int'((pc >> 2) & 32'd63);
    rd = running ? mtab[nidx] : 0;
    if (running && exb) begin
      t = mtab[m_ex_idx] + (ext ? 1 : -1);
      if (t > 3) t = 3;
      if (t < 0) t = 0;
      mtab[m_ex_idx] = t;
    end
    if (exf || ids) begin
      m_ex_pred = 0; m_ex_idx = 0;
    end else begin
      m_ex_pred = m_id_pred; m_ex_idx = m_id_idx;
    end
    if (idf) begin
      m_id_pred = 0; m_id_idx = 0;
    end else if (!ids) begin
      m_id_pred = rd; m_id_idx = nidx;
    end
    if (m_edges < 1000) m_edges++;
    if (m_edges == 64) foreach (mtab[i]) mtab[i] = 1;
    #1;
    last_id = ID_branch_prediction;
    check("id_pred", ID_branch_prediction, m_id_pred[1:0]);
    check("init_done", init_done, (m_edges >= 65) ? 1'b1 : 1'b0);
  endtask

  initial begin
    foreach (mtab[i]) mtab[i] = 0;
    do_reset();

    // Power-up sweep: 64 idle cycles, init_done rises on the 65th.
    for (int i = 0; i < 64; i++) cycle(32'h0, 0, 0, 0, 0, 0);
    check("init_done_c64", init_done, 1'b0);
    cycle(32'h0, 0, 0, 0, 0, 0);
    check("init_done_c65", init_done, 1'b1);

    // Every entry reads weakly-not-taken after the sweep.
    for (int i = 0; i < 64; i++) begin
      cycle(32'(i * 4), 0, 0, 0, 0, 0);
      check("sweep_entry", ID_branch_prediction, 2'b01);
    end

    // Branch at 0x40 taken three times.
    cycle(32'h40, 0, 0, 0, 0, 0);
    cycle(32'h40, 0, 0, 0, 0, 0);
    cycle(32'h80, 0, 0, 0, 1, 1);
    check("taken1_status", last_status, 2'd0);
    cycle(32'h40, 0, 0, 0, 1, 1);
    check("taken2_status", last_status, 2'd0);
    cycle(32'h80, 0, 0, 0, 0, 0);
    cycle(32'h40, 0, 0, 0, 1, 1);
    check("taken3_status", last_status, 2'd2);
    check("entry16_sat", last_id, 2'b11);

    // Not-taken on a saturated entry.
    cycle(32'h00, 0, 0, 0, 0, 0);
    cycle(32'h00, 0, 0, 0, 1, 0);
    check("nt_status", last_status, 2'd1);
    cycle(32'h40, 0, 0, 0, 0, 0);
    check("entry16_dec", last_id, 2'b10);

    // Retrain to 11, then flush and stall with it in flight.
    cycle(32'h00, 0, 0, 0, 0, 0);
    cycle(32'h00, 0, 0, 0, 1, 1);
    cycle(32'h40, 0, 0, 0, 0, 0);
    check("refill_11", last_id, 2'b11);
    cycle(32'h40, 1, 0, 0, 0, 0);
    check("id_flush", last_id, 2'b00);
    cycle(32'h40, 0, 0, 0, 0, 0);
    check("refetch_11", last_id, 2'b11);
    cycle(32'h80, 0, 1, 0, 0, 0);
    check("stall_hold", last_id, 2'b11);
    check("stall_status", last_status, 2'd3);
    cycle(32'h00, 0, 0, 0, 1, 1);
    check("stall_bubble", last_status, 2'd0);

    // Reset mid-sweep restarts it from entry 0.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(32'h0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 64; i++) cycle(32'h0, 0, 0, 0, 0, 0);
    check("resweep_c64", init_done, 1'b0);
    cycle(32'h0, 0, 0, 0, 0, 0);
    check("resweep_c65", init_done, 1'b1);

    // Same-index read during training returns the old value.
    cycle(32'h40, 0, 0, 0, 0, 0);
    cycle(32'h00, 0, 0, 0, 0, 0);
    cycle(32'h40, 0, 0, 0, 1, 1);
    check("rw_old_value", last_id, 2'b01);
    cycle(32'h40, 0, 0, 0, 0, 0);
    check("rw_new_value", last_id, 2'b10);

    // Randomized traffic on a few colliding indices with noise in unused PC bits.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
      cycle(pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
